// File: rtl/brush_motor_pkg.sv
// Shared constants for the brush-motor H-bridge gate stage: register map, ID,
// per-leg state encoding and the dead-time clamp helper.
// No logic of its own.
package brush_motor_pkg;

    localparam logic [31:0] HB_ID = 32'hEA680013;

    localparam logic [2:0] ADDR_ID     = 3'd0;
    localparam logic [2:0] ADDR_DT     = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;

    // Leg FSM encoding
    localparam logic [2:0] LEG_OFF   = 3'd0;
    localparam logic [2:0] LEG_DT_LO = 3'd1;
    localparam logic [2:0] LEG_LO_ON = 3'd2;
    localparam logic [2:0] LEG_DT_HI = 3'd3;
    localparam logic [2:0] LEG_HI_ON = 3'd4;

    // Gate snapshot as reported in STATUS[7:4]
    typedef struct packed {
        logic ah;
        logic al;
        logic bh;
        logic bl;
    } gates_t;

    // A dead time of zero would never expire; treat it as one cycle.
    function automatic logic [15:0] dt_eff(input logic [15:0] dt);
        return (dt == 16'd0) ? 16'd1 : dt;
    endfunction

endpackage

// File: rtl/hbridge_deadtime_leg.sv
// Purpose: one H-bridge leg; turns a high/low command into hi/lo gate drives with a dead gap.
// Latency: off-gate falls 1 edge after cmd changes; on-gate rises max(dt,1) edges later.
// Backpressure: none; kill or !en forces both gates off on the next edge.
module hbridge_deadtime_leg
    import brush_motor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd,
    input  logic        en,
    input  logic        kill,
    input  logic [15:0] dt,
    output logic        hi,
    output logic        lo
);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    // Set when DT_LO was entered from HI_ON: only then may the high side
    // come straight back, because the low side has not driven since.
    logic        from_hi_q, from_hi_d;
    logic        hi_q, hi_d;
    logic        lo_q, lo_d;

    // Next-state, dead-time counter and registered gate values
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        from_hi_d = from_hi_q;
        case (state_q)
            LEG_OFF: begin
                state_d   = LEG_DT_LO;
                cnt_d     = dt_eff(dt);
                from_hi_d = 1'b0;
            end
            LEG_DT_LO: begin
                if (from_hi_q && cmd) begin
                    state_d = LEG_HI_ON;
                end else if (cnt_q == 16'd1) begin
                    if (cmd) begin
                        state_d = LEG_DT_HI;
                        cnt_d   = dt_eff(dt);
                    end else begin
                        state_d = LEG_LO_ON;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            LEG_LO_ON: begin
                if (cmd) begin
                    state_d = LEG_DT_HI;
                    cnt_d   = dt_eff(dt);
                end
            end
            LEG_DT_HI: begin
                if (!cmd) begin
                    state_d = LEG_LO_ON;
                end else if (cnt_q == 16'd1) begin
                    state_d = LEG_HI_ON;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            LEG_HI_ON: begin
                if (!cmd) begin
                    state_d   = LEG_DT_LO;
                    cnt_d     = dt_eff(dt);
                    from_hi_d = 1'b1;
                end
            end
            default: state_d = LEG_OFF;
        endcase
        if (!en || kill) begin
            state_d = LEG_OFF;
        end
        hi_d = (state_d == LEG_HI_ON);
        lo_d = (state_d == LEG_LO_ON);
    end

    // State, counter and gate flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LEG_OFF;
            cnt_q     <= 16'd0;
            from_hi_q <= 1'b0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            from_hi_q <= from_hi_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/hbridge_deadtime_gate.sv
// Purpose: H-bridge gate drive with dead time, fault latch and Avalon-MM config/status.
// Latency: HX/HY edge to off-gate fall SYNC_STAGES+1 edges; readdata valid the edge after read.
// Backpressure: none; waitrequest tied low, every access completes in one cycle.
module hbridge_deadtime_gate
    import brush_motor_pkg::*;
#(
    parameter int DEFAULT_DT  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_ctrl_address,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    input  logic        HX,
    input  logic        HY,
    input  logic        OC_FAULT,
    output logic        AH,
    output logic        AL,
    output logic        BH,
    output logic        BL
);

    logic clk;
    logic rst;
    assign clk = csi_MCLK_clk;
    assign rst = rsi_MRST_reset;

    logic [SYNC_STAGES-1:0] hx_sync_q, hx_sync_d;
    logic [SYNC_STAGES-1:0] hy_sync_q, hy_sync_d;
    logic [SYNC_STAGES-1:0] oc_sync_q, oc_sync_d;
    logic [15:0] dt_q, dt_d;
    logic        enable_q, enable_d;
    logic        fault_q, fault_d;
    logic        cause_oc_q, cause_oc_d;
    logic        cause_both_q, cause_both_d;
    logic [31:0] readdata_q, readdata_d;

    logic   hx_s, hy_s, oc_s;
    logic   oc_det, both_det, fault_cond, fault_clr, kill;
    gates_t gates;
    logic   unused_avs;

    assign hx_s = hx_sync_q[SYNC_STAGES-1];
    assign hy_s = hy_sync_q[SYNC_STAGES-1];
    assign oc_s = oc_sync_q[SYNC_STAGES-1];

    assign gates      = '{ah: AH, al: AL, bh: BH, bl: BL};
    assign unused_avs = ^{avs_ctrl_writedata[31:16], avs_ctrl_byteenable[3:2]};

    // Synchroniser shift, register writes, fault latch and read mux
    always_comb begin
        hx_sync_d = {hx_sync_q[SYNC_STAGES-2:0], HX};
        hy_sync_d = {hy_sync_q[SYNC_STAGES-2:0], HY};
        oc_sync_d = {oc_sync_q[SYNC_STAGES-2:0], OC_FAULT};

        dt_d      = dt_q;
        enable_d  = enable_q;
        fault_clr = 1'b0;
        if (avs_ctrl_write && avs_ctrl_address == ADDR_DT) begin
            if (avs_ctrl_byteenable[0]) dt_d[7:0]  = avs_ctrl_writedata[7:0];
            if (avs_ctrl_byteenable[1]) dt_d[15:8] = avs_ctrl_writedata[15:8];
        end
        if (avs_ctrl_write && avs_ctrl_address == ADDR_CTRL) begin
            enable_d  = avs_ctrl_writedata[0];
            fault_clr = avs_ctrl_writedata[1];
        end

        // A fault present in the clear cycle beats the clear.
        oc_det       = enable_q & oc_s;
        both_det     = enable_q & hx_s & hy_s;
        fault_cond   = oc_det | both_det;
        fault_d      = fault_q;
        cause_oc_d   = cause_oc_q;
        cause_both_d = cause_both_q;
        if (fault_cond) begin
            fault_d      = 1'b1;
            cause_oc_d   = cause_oc_q | oc_det;
            cause_both_d = cause_both_q | both_det;
        end else if (fault_clr) begin
            fault_d      = 1'b0;
            cause_oc_d   = 1'b0;
            cause_both_d = 1'b0;
        end

        readdata_d = readdata_q;
        if (avs_ctrl_read) begin
            case (avs_ctrl_address)
                ADDR_ID:     readdata_d = HB_ID;
                ADDR_DT:     readdata_d = {16'd0, dt_q};
                ADDR_CTRL:   readdata_d = {31'd0, enable_q};
                ADDR_STATUS: readdata_d = {24'd0, gates, 1'b0, cause_both_q, cause_oc_q, fault_q};
                default:     readdata_d = 32'd0;
            endcase
        end
    end

    // Legs are killed in the detection cycle itself so gates drop one edge after detection
    assign kill = fault_q | fault_cond;

    // Register, synchroniser and fault flops
    always_ff @(posedge clk) begin
        if (rst) begin
            hx_sync_q    <= '0;
            hy_sync_q    <= '0;
            oc_sync_q    <= '0;
            dt_q         <= 16'(DEFAULT_DT);
            enable_q     <= 1'b0;
            fault_q      <= 1'b0;
            cause_oc_q   <= 1'b0;
            cause_both_q <= 1'b0;
            readdata_q   <= 32'd0;
        end else begin
            hx_sync_q    <= hx_sync_d;
            hy_sync_q    <= hy_sync_d;
            oc_sync_q    <= oc_sync_d;
            dt_q         <= dt_d;
            enable_q     <= enable_d;
            fault_q      <= fault_d;
            cause_oc_q   <= cause_oc_d;
            cause_both_q <= cause_both_d;
            readdata_q   <= readdata_d;
        end
    end

    hbridge_deadtime_leg u_leg_a (
        .clk  (clk),
        .rst  (rst),
        .cmd  (hx_s),
        .en   (enable_q),
        .kill (kill),
        .dt   (dt_q),
        .hi   (AH),
        .lo   (AL)
    );

    hbridge_deadtime_leg u_leg_b (
        .clk  (clk),
        .rst  (rst),
        .cmd  (hy_s),
        .en   (enable_q),
        .kill (kill),
        .dt   (dt_q),
        .hi   (BH),
        .lo   (BL)
    );

    assign avs_ctrl_readdata    = readdata_q;
    assign avs_ctrl_waitrequest = 1'b0;

endmodule

// File: tb/tb_hbridge_deadtime_gate.sv
// Directed bench for the H-bridge dead-time gate stage.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Each task checks its own feature and steps the shared counters.
module tb_hbridge_deadtime_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  address;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        write, read;
    logic [31:0] rdata;
    logic        waitreq;
    logic        hx, hy, oc;
    logic        ah, al, bh, bl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hbridge_deadtime_gate #(.DEFAULT_DT(16), .SYNC_STAGES(2)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_address     (address),
        .avs_ctrl_writedata   (wdata),
        .avs_ctrl_byteenable  (be),
        .avs_ctrl_write       (write),
        .avs_ctrl_read        (read),
        .avs_ctrl_readdata    (rdata),
        .avs_ctrl_waitrequest (waitreq),
        .HX                   (hx),
        .HY                   (hy),
        .OC_FAULT             (oc),
        .AH                   (ah),
        .AL                   (al),
        .BH                   (bh),
        .BL                   (bl)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic avs_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        address = a; wdata = d; be = b; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        step();
        read = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({ah, al, bh, bl} !== 4'b0000) begin
            bad++; $display("FAIL reset_gates: got %b want 0000", {ah, al, bh, bl});
        end
        total++;
        if (rdata !== 32'd0) begin
            bad++; $display("FAIL reset_readdata: got %h want 00000000", rdata);
        end
        total++;
        if (waitreq !== 1'b0) begin
            bad++; $display("FAIL waitrequest: got %b want 0", waitreq);
        end
        rst = 1'b0;
        avs_read(3'd0, rd);
        total++;
        if (rd !== 32'hEA680013) begin bad++; $display("FAIL read_id: got %h want ea680013", rd); end
        avs_read(3'd1, rd);
        total++;
        if (rd !== 32'd16) begin bad++; $display("FAIL read_dt_reset: got %h want 00000010", rd); end
        avs_read(3'd2, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL read_ctrl_reset: got %h want 00000000", rd); end
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL read_status_reset: got %h want 00000000", rd); end
        avs_read(3'd6, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL read_unmapped: got %h want 00000000", rd); end
    endtask

    task automatic test_deadtime();
        int n;
        logic [1:0] exp_hl;
        avs_write(3'd1, 32'd4, 4'b0011);
        avs_write(3'd2, 32'd1, 4'b1111);
        // OFF -> DT_LO on the first edge, four dead edges, low on at the fifth
        n = 0;
        while (n < 20 && al !== 1'b1) begin step(); n++; end
        total++;
        if (n !== 5 || {al, bl} !== 2'b11) begin
            bad++; $display("FAIL startup_low: edges=%0d al/bl=%b want edges=5 al/bl=11", n, {al, bl});
        end
        hx = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_hl = {(i >= 7), (i < 3)};
            total++;
            if ({ah, al} !== exp_hl) begin
                bad++; $display("FAIL rise_gap edge %0d: ah/al=%b want %b", i, {ah, al}, exp_hl);
            end
        end
        hx = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            exp_hl = {(i < 3), (i >= 7)};
            total++;
            if ({ah, al} !== exp_hl) begin
                bad++; $display("FAIL fall_gap edge %0d: ah/al=%b want %b", i, {ah, al}, exp_hl);
            end
        end
    endtask

    task automatic test_pulse_swallow();
        logic seen_ah, overlap;
        avs_write(3'd1, 32'd8, 4'b0011);
        seen_ah = 1'b0; overlap = 1'b0;
        hx = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (i == 3) hx = 1'b0;
            step();
            seen_ah = seen_ah | ah;
            overlap = overlap | (ah & al);
        end
        total++;
        if (seen_ah !== 1'b0) begin bad++; $display("FAIL swallow_ah: got %b want 0", seen_ah); end
        total++;
        if (overlap !== 1'b0) begin bad++; $display("FAIL swallow_overlap: got %b want 0", overlap); end
        total++;
        if (al !== 1'b1) begin bad++; $display("FAIL swallow_al_back: got %b want 1", al); end
    endtask

    task automatic test_fault_both();
        logic [31:0] rd;
        int bl_at, ah_at;
        logic al_seen;
        hx = 1'b1; hy = 1'b1;
        step();
        hx = 1'b0; hy = 1'b0;
        repeat (12) step();
        total++;
        if ({ah, al, bh, bl} !== 4'b0000) begin
            bad++; $display("FAIL both_high_gates_off: got %b want 0000", {ah, al, bh, bl});
        end
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h05) begin bad++; $display("FAIL both_high_status: got %h want 00000005", rd); end
        hx = 1'b1; hy = 1'b1;
        repeat (3) step();
        avs_write(3'd2, 32'd3, 4'b1111);
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h05) begin bad++; $display("FAIL clear_blocked: got %h want 00000005", rd); end
        hy = 1'b0;
        repeat (3) step();
        avs_write(3'd2, 32'd3, 4'b1111);
        bl_at = 0; ah_at = 0; al_seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bl === 1'b1 && bl_at == 0) bl_at = i;
            if (ah === 1'b1 && ah_at == 0) ah_at = i;
            al_seen = al_seen | al;
        end
        total++;
        if (bl_at !== 9) begin bad++; $display("FAIL restart_bl: edge=%0d want 9", bl_at); end
        total++;
        if (ah_at !== 17) begin bad++; $display("FAIL restart_ah: edge=%0d want 17", ah_at); end
        total++;
        if (al_seen !== 1'b0) begin bad++; $display("FAIL restart_al: got %b want 0", al_seen); end
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h90) begin bad++; $display("FAIL restart_status: got %h want 00000090", rd); end
    endtask

    task automatic test_fault_oc();
        logic [31:0] rd;
        oc = 1'b1;
        step();
        oc = 1'b0;
        step();
        total++;
        if ({ah, bl} !== 2'b11) begin bad++; $display("FAIL oc_edge2: ah/bl=%b want 11", {ah, bl}); end
        step();
        total++;
        if ({ah, bl} !== 2'b00) begin bad++; $display("FAIL oc_edge3: ah/bl=%b want 00", {ah, bl}); end
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h03) begin bad++; $display("FAIL oc_status: got %h want 00000003", rd); end
        // synchronised OC high exactly in the clear cycle
        oc = 1'b1;
        step();
        oc = 1'b0;
        step();
        avs_write(3'd2, 32'd3, 4'b1111);
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h03) begin bad++; $display("FAIL oc_clear_same_cycle: got %h want 00000003", rd); end
        hx = 1'b1; hy = 1'b1;
        repeat (3) step();
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h07) begin bad++; $display("FAIL cause_accumulate: got %h want 00000007", rd); end
        hy = 1'b0;
        repeat (3) step();
        avs_write(3'd2, 32'd1, 4'b1111);
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h07) begin bad++; $display("FAIL enable_write_keeps_fault: got %h want 00000007", rd); end
        avs_write(3'd2, 32'd3, 4'b1111);
        avs_read(3'd3, rd);
        total++;
        if (rd !== 32'h00) begin bad++; $display("FAIL oc_clear: got %h want 00000000", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int n, fall_at, rise_at;
        hx = 1'b0; hy = 1'b1;
        n = 0;
        while (n < 60 && bh !== 1'b1) begin step(); n++; end
        total++;
        if (bh !== 1'b1) begin bad++; $display("FAIL bh_before_reset: got %b want 1", bh); end
        rst = 1'b1;
        step();
        total++;
        if ({ah, al, bh, bl} !== 4'b0000) begin
            bad++; $display("FAIL reset_mid_gates: got %b want 0000", {ah, al, bh, bl});
        end
        step();
        rst = 1'b0; hy = 1'b0;
        avs_read(3'd1, rd);
        total++;
        if (rd !== 32'd16) begin bad++; $display("FAIL reset_mid_dt: got %h want 00000010", rd); end
        avs_read(3'd2, rd);
        total++;
        if (rd !== 32'd0) begin bad++; $display("FAIL reset_mid_ctrl: got %h want 00000000", rd); end
        avs_write(3'd1, 32'd0, 4'b0011);
        avs_write(3'd2, 32'd1, 4'b1111);
        n = 0;
        while (n < 20 && al !== 1'b1) begin step(); n++; end
        total++;
        if (n !== 2) begin bad++; $display("FAIL dt0_startup: edges=%0d want 2", n); end
        hx = 1'b1;
        fall_at = 0; rise_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (al === 1'b0 && fall_at == 0) fall_at = i;
            if (ah === 1'b1 && rise_at == 0) rise_at = i;
        end
        total++;
        if (fall_at !== 3 || rise_at !== 4) begin
            bad++; $display("FAIL dt0_gap: fall=%0d rise=%0d want fall=3 rise=4", fall_at, rise_at);
        end
    endtask

    task automatic test_random();
        int hold, pat;
        int a_lo_last, a_hi_last, b_lo_last, b_hi_last;
        logic pah, pal, pbh, pbl;
        avs_write(3'd1, 32'd3, 4'b0011);
        hx = 1'b0; hy = 1'b0;
        hold = 0;
        pah = ah; pal = al; pbh = bh; pbl = bl;
        a_hi_last = ah ? 0 : -1000; a_lo_last = al ? 0 : -1000;
        b_hi_last = bh ? 0 : -1000; b_lo_last = bl ? 0 : -1000;
        for (int i = 1; i <= 400; i++) begin
            if (hold == 0) begin
                pat  = int'($urandom_range(2, 0));
                hx   = (pat == 1);
                hy   = (pat == 2);
                hold = int'($urandom_range(8, 1));
            end
            hold--;
            step();
            total++;
            if (((ah & al) | (bh & bl)) !== 1'b0) begin
                bad++; $display("FAIL overlap cycle %0d: gates=%b", i, {ah, al, bh, bl});
            end
            if (ah && !pah) begin
                total++;
                if (i - a_lo_last < 4) begin bad++; $display("FAIL gap_ah cycle %0d: gap=%0d want >=4", i, i - a_lo_last); end
            end
            if (al && !pal) begin
                total++;
                if (i - a_hi_last < 4) begin bad++; $display("FAIL gap_al cycle %0d: gap=%0d want >=4", i, i - a_hi_last); end
            end
            if (bh && !pbh) begin
                total++;
                if (i - b_lo_last < 4) begin bad++; $display("FAIL gap_bh cycle %0d: gap=%0d want >=4", i, i - b_lo_last); end
            end
            if (bl && !pbl) begin
                total++;
                if (i - b_hi_last < 4) begin bad++; $display("FAIL gap_bl cycle %0d: gap=%0d want >=4", i, i - b_hi_last); end
            end
            if (ah) a_hi_last = i;
            if (al) a_lo_last = i;
            if (bh) b_hi_last = i;
            if (bl) b_lo_last = i;
            pah = ah; pal = al; pbh = bh; pbl = bl;
        end
    endtask

    initial begin
        rst = 1'b1; address = 3'd0; wdata = 32'd0; be = 4'd0;
        write = 1'b0; read = 1'b0; hx = 1'b0; hy = 1'b0; oc = 1'b0;
        test_reset();
        test_deadtime();
        test_pulse_swallow();
        test_fault_both();
        test_fault_oc();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
